// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding and
// default operand/digit sizes.
package bcd_pkg;

  localparam int N_BITS_DEF   = 8;
  localparam int N_DIGITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 (mod 16) to a BCD digit of 5 or more.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // +3 correction so the following left shift carries into the next digit
  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter: one double-dabble step per SHIFT cycle,
// result registered on completion with a one-cycle done pulse.
module bcd_conv_ctrl
  import bcd_pkg::*;
#(
  parameter int N_BITS   = N_BITS_DEF,
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_BITS-1:0]       bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N_BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  bcd_state_t        state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [N_BITS-1:0] op_r, op_s;
  logic [DW-1:0]     dig_r, dig_s;
  logic [DW-1:0]     bcd_r, bcd_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [DW-1:0]     dig_add_s;
  logic [DW-1:0]     dig_shift_s;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (dig_r[4*g +: 4]),
      .q (dig_add_s[4*g +: 4])
    );
  end

  // The operand MSB shifts into the corrected digit chain
  assign dig_shift_s = {dig_add_s[DW-2:0], op_r[N_BITS-1]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    dig_s   = dig_r;
    bcd_s   = bcd_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = SHIFT;
          op_s    = bin_in;
          dig_s   = {DW{1'b0}};
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        dig_s = dig_shift_s;
        op_s  = op_r << 1;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
          bcd_s   = dig_shift_s;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == SHIFT);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= {N_BITS{1'b0}};
      dig_r   <= {DW{1'b0}};
      bcd_r   <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      dig_r   <= dig_s;
      bcd_r   <= bcd_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bcd_out = bcd_r;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Self-checking bench for bcd_conv_ctrl: directed cases, random traffic against
// a cycle-timeline model, and an exhaustive sweep of a 4-bit instance.
module tb_bcd_conv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  logic        start2;
  logic [3:0]  bin2;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;

  int vec  = 0;
  int errs = 0;
  bit en_cmp = 1'b0;

  bcd_conv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  bcd_conv_ctrl #(.N_BITS(4), .N_DIGITS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by repeated division, packed MSD in the top nibble
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = 12'h000;
    x = v;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Timeline model: a conversion occupies 8 busy cycles after acceptance,
  // then one done cycle in which a new request may be accepted.
  int          m_rem;
  logic        m_done;
  logic [11:0] m_bcd;
  logic [7:0]  m_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_bcd  <= 12'h000;
      m_val  <= 8'd0;
    end else if (m_rem != 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_bcd <= to_bcd(int'(m_val));
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_val <= bin_in;
        m_rem <= 8;
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      chk("model_busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_bcd", {20'd0, bcd_out}, {20'd0, m_bcd});
      for (int i = 0; i < 3; i++) begin
        chk("digit_range", {31'd0, (bcd_out[4*i +: 4] > 4'd9)}, 32'd0);
      end
    end
  end

  // Waits for done, counting edges from the accepting edge (edge 1)
  task automatic wait_done(input int e0, output int e, output int b);
    e = e0;
    b = 0;
    while (done !== 1'b1 && e < 30) begin
      if (busy === 1'b1) b++;
      @(posedge clk); #1;
      e++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_conv(input logic [7:0] v, input logic [11:0] exp);
    int e, b;
    @(posedge clk); #1;
    start = 1'b1; bin_in = v;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, e, b);
    chk("done_edge", e, 32'd9);
    chk("busy_cycles", b, 32'd8);
    chk("result", {20'd0, bcd_out}, {20'd0, exp});
  endtask

  task automatic no_done_for(input int n, input logic [11:0] hold);
    int pulses;
    pulses = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
      chk("hold_bcd", {20'd0, bcd_out}, {20'd0, hold});
    end
    chk("spurious_done", pulses, 32'd0);
  endtask

  initial begin
    int e, b;
    logic [7:0] exp4;
    rst_n = 1'b0; start = 1'b0; bin_in = 8'd0; start2 = 1'b0; bin2 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {20'd0, bcd_out}, 32'd0);
    chk("rst_bcd4", {24'd0, bcd2}, 32'd0);
    rst_n = 1'b1;
    en_cmp = 1'b1;

    do_conv(8'd255, 12'h255);
    do_conv(8'd0,   12'h000);
    do_conv(8'd99,  12'h099);
    do_conv(8'd100, 12'h100);

    // Back-to-back with start held high, operand changed in the DONE cycle
    @(posedge clk); #1;
    start = 1'b1; bin_in = 8'd37;
    @(posedge clk); #1;
    wait_done(1, e, b);
    chk("b2b_edge1", e, 32'd9);
    chk("b2b_res1", {20'd0, bcd_out}, 32'h037);
    bin_in = 8'd200;
    @(posedge clk); #1;
    chk("b2b_no_gap", {31'd0, busy}, 32'd1);
    wait_done(1, e, b);
    chk("b2b_edge2", e, 32'd9);
    chk("b2b_res2", {20'd0, bcd_out}, 32'h200);
    start = 1'b0;

    // Request during SHIFT cycle 3 must be dropped
    @(posedge clk); #1;
    start = 1'b1; bin_in = 8'd150;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; bin_in = 8'd77;
    @(posedge clk); #1;
    start = 1'b0; bin_in = 8'd0;
    wait_done(4, e, b);
    chk("drop_edge", e, 32'd9);
    chk("drop_res", {20'd0, bcd_out}, 32'h150);
    no_done_for(15, 12'h150);

    // Asynchronous reset at SHIFT cycle 5
    @(posedge clk); #1;
    start = 1'b1; bin_in = 8'd213;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_bcd", {20'd0, bcd_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    no_done_for(15, 12'h000);
    do_conv(8'd42, 12'h042);

    // Random traffic, including requests while busy and back-to-back starts
    repeat (400) begin
      @(posedge clk); #1;
      start  = ($urandom_range(0, 3) == 0);
      bin_in = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);

    // Exhaustive sweep of the 4-bit / 2-digit instance
    for (int v = 0; v < 16; v++) begin
      @(posedge clk); #1;
      start2 = 1'b1; bin2 = 4'(v);
      @(posedge clk); #1;
      start2 = 1'b0;
      e = 1;
      while (done2 !== 1'b1 && e < 20) begin
        @(posedge clk); #1;
        e++;
      end
      exp4 = (v < 10) ? 8'(v) : 8'(v + 6);
      chk("sweep4_edge", e, 32'd5);
      chk("sweep4_res", {24'd0, bcd2}, {24'd0, exp4});
    end

    @(negedge clk);
    en_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
